// File: rtl/median3_stream_ctrl.sv
// 3-tap sliding-window median filter with edge replication and valid/ready handshakes.
// Optional MEDIAN3_FRAME_CNT_EN adds a 16-bit out_index (position of result within frame).
module median3_stream_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
`ifdef MEDIAN3_FRAME_CNT_EN
    ,
    output logic [15:0]      out_index
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] w0, w1;
    logic             slot_free, accept;
    logic             load, load_last, win_init, win_shift;
    logic [WIDTH-1:0] load_data, med;

    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a, b, c);
        logic [WIDTH-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c < lo)      return lo;
        else if (c > hi) return hi;
        else             return c;
    endfunction

    assign slot_free = !out_valid || out_ready;
    // Gated by rst so the source sees not-ready throughout reset.
    assign in_ready  = !rst && (state != TAIL) && slot_free;
    assign accept    = in_valid && in_ready;
    assign med       = med3(w0, w1, in_data);
    assign busy      = (state != IDLE) || out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !in_last) next_state = RUN;
            RUN:     if (accept && in_last)  next_state = TAIL;
            TAIL:    if (slot_free)          next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load      = 1'b0;
        load_data = in_data;
        load_last = 1'b0;
        win_init  = 1'b0;
        win_shift = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (in_last) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                end else begin
                    win_init  = 1'b1;
                end
            end
            RUN: if (accept) begin
                load      = 1'b1;
                load_data = med;
                win_shift = 1'b1;
            end
            // Replicating the end sample makes the median collapse to w1.
            TAIL: if (slot_free) begin
                load      = 1'b1;
                load_data = w1;
                load_last = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w0        <= '0;
            w1        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (win_init) begin
                w0 <= in_data;
                w1 <= in_data;
            end else if (win_shift) begin
                w0 <= w1;
                w1 <= in_data;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_last  <= load_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MEDIAN3_FRAME_CNT_EN
    logic [15:0] idx_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_cnt   <= '0;
            out_index <= '0;
        end else if (load) begin
            out_index <= idx_cnt;
            if (load_last)               idx_cnt <= '0;
            else if (idx_cnt != 16'hFFFF) idx_cnt <= idx_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_median3_stream_ctrl.sv
// Directed bench for median3_stream_ctrl: inputs driven on negedge, outputs checked on the next negedge.
module tb_median3_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_last;
    logic [7:0] in_data;
    logic       out_valid, out_ready, out_last, busy;
    logic [7:0] out_data;
`ifdef MEDIAN3_FRAME_CNT_EN
    logic [15:0] out_index;
`endif

    int checks = 0;
    int errors = 0;

    median3_stream_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy)
`ifdef MEDIAN3_FRAME_CNT_EN
        , .out_index(out_index)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic exp_out(input string tag, input logic v, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
            chk({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
        end
    endtask

    // Present inputs, let one rising edge pass, return at the following negedge.
    task automatic step(input logic v, input logic [7:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Frame 10,50,20,40,30 -> 10,20,40,30,30
        step(1, 8'd10, 0); exp_out("f1_a", 0, 0, 0);
        chk("f1_busy", {31'd0, busy}, 32'd1);
        step(1, 8'd50, 0); exp_out("f1_o0", 1, 8'd10, 0);
        step(1, 8'd20, 0); exp_out("f1_o1", 1, 8'd20, 0);
        step(1, 8'd40, 0); exp_out("f1_o2", 1, 8'd40, 0);
        step(1, 8'd30, 1); exp_out("f1_o3", 1, 8'd30, 0);
        chk("f1_tail_in_ready", {31'd0, in_ready}, 32'd0);
        step(0, 8'd0, 0);  exp_out("f1_o4", 1, 8'd30, 1);
        step(0, 8'd0, 0);  exp_out("f1_done", 0, 0, 0);

        // Single-sample frame, then next frame immediately (impulse 0,255,0)
        step(1, 8'd77, 1); exp_out("single", 1, 8'd77, 1);
        chk("single_in_ready", {31'd0, in_ready}, 32'd1);
        step(1, 8'd0, 0);  exp_out("imp_a", 0, 0, 0);
        step(1, 8'd255, 0); exp_out("imp_o0", 1, 8'd0, 0);
        step(1, 8'd0, 1);  exp_out("imp_o1", 1, 8'd0, 0);
        step(0, 8'd0, 0);  exp_out("imp_o2", 1, 8'd0, 1);

        // Two-sample frame 5,200
        step(1, 8'd5, 0);  exp_out("two_a", 0, 0, 0);
        step(1, 8'd200, 1); exp_out("two_o0", 1, 8'd5, 0);
        step(0, 8'd0, 0);  exp_out("two_o1", 1, 8'd200, 1);
        step(0, 8'd0, 0);  exp_out("two_done", 0, 0, 0);
        chk("two_busy", {31'd0, busy}, 32'd0);

        // Backpressure: frame 1,2,3,4,5 with a 4-cycle stall -> 1,2,3,4,5
        step(1, 8'd1, 0);
        step(1, 8'd2, 0);  exp_out("bp_o0", 1, 8'd1, 0);
        step(1, 8'd3, 0);  exp_out("bp_o1", 1, 8'd2, 0);
        out_ready = 1'b0;
        in_data = 8'd4;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); @(negedge clk);
            exp_out("bp_hold", 1, 8'd2, 0);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        step(1, 8'd4, 0);  exp_out("bp_o2", 1, 8'd3, 0);
        step(1, 8'd5, 1);  exp_out("bp_o3", 1, 8'd4, 0);
        step(0, 8'd0, 0);  exp_out("bp_o4", 1, 8'd5, 1);
        step(0, 8'd0, 0);  exp_out("bp_done", 0, 0, 0);

        // Async reset mid-frame with a pending output
        step(1, 8'd7, 0);
        step(1, 8'd8, 0);  exp_out("ar_pre", 1, 8'd7, 0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_out_data", {24'd0, out_data}, 32'd0);
        chk("ar_out_last", {31'd0, out_last}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ar_rel_in_ready", {31'd0, in_ready}, 32'd1);
        step(1, 8'd3, 0);  exp_out("ar_a", 0, 0, 0);
        step(1, 8'd3, 0);  exp_out("ar_o0", 1, 8'd3, 0);
        step(1, 8'd9, 1);  exp_out("ar_o1", 1, 8'd3, 0);
        step(0, 8'd0, 0);  exp_out("ar_o2", 1, 8'd9, 1);
        step(0, 8'd0, 0);  exp_out("ar_done", 0, 0, 0);

`ifdef MEDIAN3_FRAME_CNT_EN
        // Two 3-sample frames -> out_index 0,1,2,0,1,2
        for (int f = 0; f < 2; f++) begin
            step(1, 8'd1, 0);
            step(1, 8'd2, 0); chk("idx0", {16'd0, out_index}, 32'd0);
            step(1, 8'd3, 1); chk("idx1", {16'd0, out_index}, 32'd1);
            step(0, 8'd0, 0); chk("idx2", {16'd0, out_index}, 32'd2);
            exp_out("idx_tail", 1, 8'd3, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/median3_stream_ctrl.md
Name: median3_stream_ctrl

Overview:
- Streaming controller that sequences a 3-input median datapath over a sample stream, acting as a 3-tap sliding-window median filter.
- Holds the window registers, applies edge replication at frame start and end, and presents the median over valid/ready handshakes.
- Sits between a sample source (for example a line or frame reader) and downstream processing; produces exactly one output per input sample.

Parameters:
- WIDTH, 8, sample and result bit width.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, source presents a sample.
- in_ready, output, 1, controller can accept a sample this cycle.
- in_data, input, WIDTH, sample value (unsigned).
- in_last, input, 1, sample is the last of its frame.
- out_valid, output, 1, out_data holds a result.
- out_ready, input, 1, sink accepts the result.
- out_data, output, WIDTH, median result.
- out_last, output, 1, result is the last of its frame.
- busy, output, 1, a frame is in progress (state != IDLE) or out_valid=1.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. While rst=1, all registers clear: state=IDLE, w0=w1=0, out_valid=0, out_data=0, out_last=0. in_ready is 0 while rst is asserted and 1 in the first cycle after release.
- Median: combinational median of three unsigned WIDTH-bit values (middle value of the sorted three). Ties return the duplicated value. No width growth.
- Handshake definitions:
  - Input accept: in_valid & in_ready.
  - Output consume: out_valid & out_ready.
  - Slot free: !out_valid | out_ready.
  - in_ready = (state != TAIL) & slot free. This is combinational from out_ready, with no dependence on in_valid.
- out_data and out_last are registered and held stable while out_valid=1 and out_ready=0. On consume with no new load, out_valid drops next cycle.
- States:
  - IDLE, accept with in_last=0: w0 <= d, w1 <= d; go to RUN; no output loaded (start-edge replication).
  - IDLE, accept with in_last=1: load out_data=d, out_last=1; stay IDLE (single-sample frame).
  - RUN, accept of d: load out_data=median(w0,w1,d), out_last=0; then w0 <= w1, w1 <= d.
    - in_last=0: stay in RUN.
    - in_last=1: go to TAIL.
  - TAIL, when slot free: load out_data=median(w0,w1,w1)=w1, out_last=1; go to IDLE. Nothing is accepted in TAIL.
- Latency: a result becomes visible (out_valid=1) the cycle after the accept that produced it. The tail result appears at the earliest free slot after the last accept.
- Throughput: one sample per cycle while out_ready=1. A frame of N samples produces N results.
- Simultaneous consume and load in one cycle: out_data is replaced and out_valid stays 1; no bubble.
- Back-to-back frames: IDLE after TAIL accepts the next frame's first sample immediately; window state never leaks across frames.
- Reset mid-frame: partial window and pending output are discarded; no out_last is emitted for the aborted frame.
- in_data, in_last and in_valid are ignored whenever in_ready=0.

Optional Feature:
- Macro: MEDIAN3_FRAME_CNT_EN.
- When defined:
  - Adds output port out_index (16 bits), the zero-based position of the current result within its frame.
  - out_index is registered alongside out_data; it resets to 0 on rst and after each out_last result is loaded.
  - It saturates at 0xFFFF.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Frame 10,50,20,40,30 (last on 30), out_ready=1 -> outputs 10,20,40,30,30; out_last only on the 5th; out_valid rises 1 cycle after the 2nd accept.
- Single-sample frame 77 with in_last=1 -> one output 77 with out_last=1; state remains IDLE; the next frame is accepted the following cycle.
- Impulse frame 0,255,0 (last) -> outputs 0,0,0. Frame 5,200 (last) -> outputs 5 then 200 (out_last=1).
- Backpressure: hold out_ready=0 for 4 cycles mid-frame -> out_data stable, in_ready=0; on release, no sample is lost or duplicated and the sequence matches the unstalled run.
- Assert rst asynchronously (between edges) during RUN with out_valid=1 -> out_valid, out_data and out_last drop to 0 immediately; a new frame 3,3,9 (last) yields 3,3,9.
- With MEDIAN3_FRAME_CNT_EN: two consecutive 3-sample frames -> out_index 0,1,2,0,1,2.
